input_layer_spike_queue: RTL and testbench

- Parametrised successor to the input-layer controller.
- Accepts one pixel per clock from the image streamer and compares it against a programmable threshold.
- Queues the indices of active pixels into a double-buffered (ping-pong) index store, so the next image can load while the previous one drains.
- Sits between the pixel source and the first hidden layer, which pops active indices one at a time.

---
 rtl/input_layer_spike_queue.sv | 186 ++++++++++++++++++
 tb/tb_input_layer_spike_queue.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_layer_spike_queue.sv
// Thresholds a raster pixel stream and queues active pixel indices into two ping-pong banks.
// Define INPUT_VALUE_OUT_EN to also store each active pixel's value and present it on valueOut.
module input_layer_spike_queue #(
  parameter int INPUT_NODES = 784,
  parameter int INDEX_WIDTH = 10,
  parameter int PIXEL_WIDTH = 8,
  parameter int THRESHOLD   = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inputsInbound,
  input  logic [PIXEL_WIDTH-1:0] pixelValue,
  input  logic                   dequeue,
  output logic                   readyForInputs,
  output logic                   outputsReady,
  output logic [INDEX_WIDTH-1:0] indexOut,
  output logic [PIXEL_WIDTH-1:0] valueOut,
  output logic                   queueEmpty,
  output logic                   batchDone,
  output logic                   droppedPixel
);
  localparam int AW = (INPUT_NODES > 1) ? $clog2(INPUT_NODES) : 1;
  localparam int CW = $clog2(INPUT_NODES + 1);

  typedef enum logic [1:0] {S_FREE, S_LOADING, S_COMMITTED, S_DRAINING} bank_state_t;

  bank_state_t            r_state      [2];
  bank_state_t            w_state_nxt  [2];
  logic [CW-1:0]          r_wr_ptr     [2];
  logic [CW-1:0]          w_wr_ptr_nxt [2];
  logic [CW-1:0]          r_rd_ptr;
  logic [CW-1:0]          w_rd_ptr_nxt;
  logic [CW-1:0]          w_rd_inc;
  logic [INDEX_WIDTH-1:0] r_pix_idx;
  logic [INDEX_WIDTH-1:0] w_pix_idx_nxt;
  logic                   r_ld_ptr;
  logic                   w_ld_ptr_nxt;
  logic                   r_dr_ptr;
  logic                   w_dr_ptr_nxt;
  logic                   r_ready;
  logic                   w_ready_nxt;
  logic [INDEX_WIDTH-1:0] r_index_mem [2][INPUT_NODES];
  logic [INDEX_WIDTH-1:0] r_index_out;
  logic                   r_batch_done;
  logic                   r_dropped;
  logic                   w_accept;
  logic                   w_drop;
  logic                   w_active;
  logic                   w_write;
  logic                   w_start_drain;
  logic                   w_pop;
  logic                   w_release;
  logic                   w_load_head;
  logic                   w_pending;
  logic [AW-1:0]          w_wr_addr;
  logic [AW-1:0]          w_rd_addr;

  // r_ready mirrors "load bank is FREE or LOADING", so it doubles as the accept gate.
  assign w_accept  = inputsInbound & r_ready;
  assign w_drop    = inputsInbound & ~r_ready;
  assign w_active  = pixelValue >= PIXEL_WIDTH'(THRESHOLD);
  assign w_write   = w_accept & w_active;
  assign w_rd_inc  = r_rd_ptr + CW'(1);
  assign w_wr_addr = r_wr_ptr[r_ld_ptr][AW-1:0];

  always_comb begin
    w_state_nxt   = r_state;
    w_wr_ptr_nxt  = r_wr_ptr;
    w_rd_ptr_nxt  = r_rd_ptr;
    w_pix_idx_nxt = r_pix_idx;
    w_ld_ptr_nxt  = r_ld_ptr;
    w_dr_ptr_nxt  = r_dr_ptr;
    w_start_drain = 1'b0;
    w_pop         = 1'b0;
    w_release     = 1'b0;

    if (w_accept) begin
      w_state_nxt[r_ld_ptr] = S_LOADING;
      if (w_active) w_wr_ptr_nxt[r_ld_ptr] = r_wr_ptr[r_ld_ptr] + CW'(1);
      if (r_pix_idx == INDEX_WIDTH'(INPUT_NODES - 1)) begin
        w_state_nxt[r_ld_ptr] = S_COMMITTED;
        w_pix_idx_nxt         = '0;
        w_ld_ptr_nxt          = ~r_ld_ptr;
      end else begin
        w_pix_idx_nxt = r_pix_idx + INDEX_WIDTH'(1);
      end
    end else if (!inputsInbound && r_state[r_ld_ptr] == S_LOADING) begin
      // Short image: the stream stopped early, remaining pixels count as inactive.
      w_state_nxt[r_ld_ptr] = S_COMMITTED;
      w_pix_idx_nxt         = '0;
      w_ld_ptr_nxt          = ~r_ld_ptr;
    end

    if (r_state[r_dr_ptr] == S_COMMITTED) begin
      w_state_nxt[r_dr_ptr] = S_DRAINING;
      w_start_drain         = 1'b1;
    end else if (r_state[r_dr_ptr] == S_DRAINING) begin
      if (r_rd_ptr == r_wr_ptr[r_dr_ptr]) begin
        w_release = 1'b1;
      end else if (dequeue) begin
        w_pop        = 1'b1;
        w_rd_ptr_nxt = w_rd_inc;
        if (w_rd_inc == r_wr_ptr[r_dr_ptr]) w_release = 1'b1;
      end
    end

    if (w_release) begin
      w_state_nxt[r_dr_ptr]  = S_FREE;
      w_wr_ptr_nxt[r_dr_ptr] = '0;
      w_rd_ptr_nxt           = '0;
      w_dr_ptr_nxt           = ~r_dr_ptr;
    end

    w_ready_nxt = (w_state_nxt[w_ld_ptr_nxt] == S_FREE) ||
                  (w_state_nxt[w_ld_ptr_nxt] == S_LOADING);
    // Head register only moves when a real entry becomes visible, so it holds otherwise.
    w_load_head = (w_start_drain && (r_wr_ptr[r_dr_ptr] != '0)) || (w_pop && !w_release);
    w_rd_addr   = w_start_drain ? '0 : w_rd_inc[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        r_state[b]  <= S_FREE;
        r_wr_ptr[b] <= '0;
      end
      r_rd_ptr     <= '0;
      r_pix_idx    <= '0;
      r_ld_ptr     <= 1'b0;
      r_dr_ptr     <= 1'b0;
      r_ready      <= 1'b1;
      r_index_out  <= '0;
      r_batch_done <= 1'b0;
      r_dropped    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_pix_idx    <= w_pix_idx_nxt;
      r_ld_ptr     <= w_ld_ptr_nxt;
      r_dr_ptr     <= w_dr_ptr_nxt;
      r_ready      <= w_ready_nxt;
      r_batch_done <= w_release;
      r_dropped    <= w_drop;
      if (w_load_head) r_index_out <= r_index_mem[r_dr_ptr][w_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) r_index_mem[r_ld_ptr][w_wr_addr] <= r_pix_idx;
  end

`ifdef INPUT_VALUE_OUT_EN
  logic [PIXEL_WIDTH-1:0] r_value_mem [2][INPUT_NODES];
  logic [PIXEL_WIDTH-1:0] r_value_out;

  always_ff @(posedge clk) begin
    if (w_write) r_value_mem[r_ld_ptr][w_wr_addr] <= pixelValue;
  end

  always_ff @(posedge clk) begin
    if (reset)            r_value_out <= '0;
    else if (w_load_head) r_value_out <= r_value_mem[r_dr_ptr][w_rd_addr];
  end

  assign valueOut = r_value_out;
`else
  assign valueOut = '0;
`endif

  always_comb begin
    w_pending = 1'b0;
    for (int b = 0; b < 2; b++) begin
      if (r_state[b] == S_COMMITTED && r_wr_ptr[b] != '0) w_pending = 1'b1;
      if (r_state[b] == S_DRAINING && r_rd_ptr < r_wr_ptr[b]) w_pending = 1'b1;
    end
  end

  assign readyForInputs = r_ready;
  assign outputsReady   = (r_state[r_dr_ptr] == S_DRAINING) && (r_rd_ptr < r_wr_ptr[r_dr_ptr]);
  assign indexOut       = r_index_out;
  assign queueEmpty     = ~w_pending;
  assign batchDone      = r_batch_done;
  assign droppedPixel   = r_dropped;

endmodule

// File: tb/tb_input_layer_spike_queue.sv
// Directed bench for input_layer_spike_queue (INPUT_NODES=10, THRESHOLD=128) with a
// queue-based reference model compared every cycle, plus hand-computed index lists.
module tb_input_layer_spike_queue;
  localparam int N  = 10;
  localparam int IW = 10;
  localparam int PW = 8;
  localparam int TH = 128;

  localparam logic [IW-1:0] A_IDX [5] = '{10'd0, 10'd1, 10'd3, 10'd5, 10'd9};
  localparam logic [PW-1:0] A_VAL [5] = '{8'd200, 8'd255, 8'd130, 8'd128, 8'd255};
  localparam logic [IW-1:0] B_IDX [6] = '{10'd0, 10'd1, 10'd3, 10'd4, 10'd6, 10'd7};
  localparam logic [IW-1:0] S_IDX [2] = '{10'd0, 10'd2};

  // clock / reset / DUT
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          inputsInbound = 1'b0;
  logic [PW-1:0] pixelValue = '0;
  logic          dequeue = 1'b0;
  logic          readyForInputs, outputsReady, queueEmpty, batchDone, droppedPixel;
  logic [IW-1:0] indexOut;
  logic [PW-1:0] valueOut;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  input_layer_spike_queue #(
    .INPUT_NODES(N), .INDEX_WIDTH(IW), .PIXEL_WIDTH(PW), .THRESHOLD(TH)
  ) dut (
    .clk(clk), .reset(reset), .inputsInbound(inputsInbound), .pixelValue(pixelValue),
    .dequeue(dequeue), .readyForInputs(readyForInputs), .outputsReady(outputsReady),
    .indexOut(indexOut), .valueOut(valueOut), .queueEmpty(queueEmpty),
    .batchDone(batchDone), .droppedPixel(droppedPixel)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // scoreboard / reference model
  logic [IW-1:0] exp_q  [$];
  logic [PW-1:0] expv_q [$];
  logic [IW-1:0] ld_q   [$];
  logic [PW-1:0] ldv_q  [$];
  int            blen_q [$];
  bit            started = 0;
  bit            loading = 0;
  bit            head_drain = 0;
  int            cur_idx = 0;
  int            rem = 0;
  bit            m_ready = 1, m_done = 0, m_drop = 0, m_ordy = 0;
  logic [IW-1:0] m_idx = '0;
  logic [PW-1:0] m_val = '0;

  task automatic commit_batch();
    blen_q.push_back(ld_q.size());
    foreach (ld_q[k]) begin
      exp_q.push_back(ld_q[k]);
      expv_q.push_back(ldv_q[k]);
    end
    ld_q.delete();
    ldv_q.delete();
    cur_idx = 0;
    loading = 0;
  endtask

  task automatic release_head();
    void'(blen_q.pop_front());
    head_drain = 0;
    m_done = 1;
  endtask

  always @(posedge clk) begin : model
    bit            acc, inb, deq;
    logic [PW-1:0] px;
    inb = inputsInbound;
    deq = dequeue;
    px  = pixelValue;
    if (reset) begin
      exp_q.delete(); expv_q.delete(); ld_q.delete(); ldv_q.delete(); blen_q.delete();
      started = 1; loading = 0; head_drain = 0; cur_idx = 0; rem = 0;
      m_ready = 1; m_done = 0; m_drop = 0; m_idx = '0; m_val = '0;
    end else if (started) begin
      m_done = 0;
      acc    = inb && (blen_q.size() < 2);
      m_drop = inb && !(blen_q.size() < 2);
      if (head_drain) begin
        if (rem == 0) release_head();
        else if (deq) begin
          void'(exp_q.pop_front());
          void'(expv_q.pop_front());
          rem--;
          if (rem == 0) release_head();
        end
      end else if (blen_q.size() > 0) begin
        head_drain = 1;
        rem = blen_q[0];
      end
      if (acc) begin
        if (px >= TH) begin
          ld_q.push_back(IW'(cur_idx));
          ldv_q.push_back(px);
        end
        loading = 1;
        if (cur_idx == N - 1) commit_batch();
        else cur_idx++;
      end else if (!inb && loading) begin
        commit_batch();
      end
      m_ready = blen_q.size() < 2;
    end
    m_ordy = head_drain && (rem > 0);
    if (m_ordy) begin
      m_idx = exp_q[0];
      m_val = expv_q[0];
    end
    #1;
    if (started) begin
      check("m_ready", readyForInputs, m_ready);
      check("m_ordy", outputsReady, m_ordy);
      check("m_empty", queueEmpty, exp_q.size() == 0);
      check("m_done", batchDone, m_done);
      check("m_drop", droppedPixel, m_drop);
      check("m_index", indexOut, m_idx);
`ifdef INPUT_VALUE_OUT_EN
      check("m_value", valueOut, m_val);
`else
      check("m_value0", valueOut, 0);
`endif
    end
  end

  // driver tasks
  logic [PW-1:0] pix_buf [0:31];

  task automatic fill(input int base, input int which);
    for (int i = 0; i < N; i++) begin
      case (which)
        0: pix_buf[base+i] = (i == 0) ? 8'd200 : (i == 1) ? 8'd255 : (i == 3) ? 8'd130 :
                             (i == 4) ? 8'd127 : (i == 5) ? 8'd128 : (i == 8) ? 8'd90 :
                             (i == 9) ? 8'd255 : 8'd0;
        1: pix_buf[base+i] = (i == 2 || i == 5 || i >= 8) ? 8'd0 : 8'd255;
        2: pix_buf[base+i] = 8'd0;
        3: pix_buf[base+i] = (i == 0) ? 8'd255 : (i == 2) ? 8'd200 : 8'd0;
        default: pix_buf[base+i] = (i == 0) ? 8'd255 : (i == 9) ? 8'd140 : 8'd0;
      endcase
    end
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      inputsInbound = 1'b1;
      pixelValue    = pix_buf[i];
    end
    @(negedge clk);
    inputsInbound = 1'b0;
    pixelValue    = '0;
  endtask

  task automatic wait_ready(output bit ok);
    int c = 0;
    while (!outputsReady && c < 40) begin
      @(negedge clk);
      c++;
    end
    ok = outputsReady;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got outputsReady=0 want 1 within 40 cycles at t=%0t", $time);
    end
  endtask

  function automatic logic [IW-1:0] want_i(input int which, input int k);
    case (which)
      0:       return A_IDX[k];
      1:       return B_IDX[k];
      default: return S_IDX[k];
    endcase
  endfunction

  task automatic drain_expect(input int which, input int n);
    bit ok;
    for (int k = 0; k < n; k++) begin
      wait_ready(ok);
      if (ok) begin
        check("lit_index", indexOut, want_i(which, k));
`ifdef INPUT_VALUE_OUT_EN
        if (which == 0) check("lit_value", valueOut, A_VAL[k]);
`else
        check("lit_value0", valueOut, 0);
`endif
        dequeue = 1'b1;
        @(negedge clk);
        dequeue = 1'b0;
      end
    end
    check("lit_batch_done", batchDone, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", readyForInputs, 1);
    check("rst_ordy", outputsReady, 0);
    check("rst_index", indexOut, 0);
    check("rst_value", valueOut, 0);
    check("rst_empty", queueEmpty, 1);
    check("rst_done", batchDone, 0);
    check("rst_drop", droppedPixel, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [IW-1:0] got_q [$];
    bit            seen_ready;
    bit            ok;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_reset_outputs();

    // batch A alone
    fill(0, 0);
    send_pixels(N);
    check("a_not_yet", outputsReady, 0);
    @(negedge clk);
    check("a_ready_1cyc", outputsReady, 1);
    drain_expect(0, 5);
    check("a_empty", queueEmpty, 1);

    // A and B back-to-back, then an overflow pixel
    fill(0, 0);
    fill(N, 1);
    pix_buf[2*N] = 8'd77;
    send_pixels(2*N + 1);
    check("ab_drop", droppedPixel, 1);
    check("ab_full", readyForInputs, 0);
    drain_expect(0, 5);
    drain_expect(1, 6);
    check("ab_empty", queueEmpty, 1);

    // all-zero batch
    fill(0, 2);
    send_pixels(N);
    seen_ready = 0;
    for (int c = 0; c < 10 && !batchDone; c++) begin
      @(negedge clk);
      seen_ready |= outputsReady;
    end
    check("zero_done", batchDone, 1);
    check("zero_no_ordy", seen_ready, 0);
    @(negedge clk);
    check("zero_ready", readyForInputs, 1);

    // short batch of 4 pixels
    fill(0, 3);
    send_pixels(4);
    drain_expect(2, 2);

    // next full batch starts at index 0, drained with dequeue held high
    fill(0, 4);
    send_pixels(N);
    dequeue = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (outputsReady) got_q.push_back(indexOut);
    end
    dequeue = 1'b0;
    check("hold_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("hold_first", got_q[0], 0);
      check("hold_last", got_q[1], 9);
    end
    check("hold_index_kept", indexOut, 9);
    check("hold_empty", queueEmpty, 1);

    // reset in the middle of a drain
    fill(0, 0);
    send_pixels(N);
    wait_ready(ok);
    dequeue = 1'b1;
    @(negedge clk);
    dequeue = 1'b0;
    check("mid_index", indexOut, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs();

    // recovery after reset
    fill(0, 1);
    send_pixels(N);
    drain_expect(1, 6);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
